// File: rtl/inst_mem_responder.sv
// inst_mem_responder
//   Responder end of the mcpu instruction-fetch interface. Holds a DEPTH-word
//   array of 16-bit instructions and answers fetch requests over a req/ack
//   handshake after WAIT_CYCLES wait states. A load port lets a boot loader or
//   bench place a program into the array while the responder is idle.
//
//   Optional feature (macro INST_PREFETCH_EN): a one-entry prefetch buffer
//   holding the word after the last fetched address. A request hitting the
//   buffer skips the wait states.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   if_req     fetch request, held with stable if_addr until if_ack
//   if_addr    fetch word address (PC)
//   if_ack     one-cycle pulse, if_inst/if_err valid
//   if_inst    fetched instruction, holds last value between acks
//   if_err     valid with if_ack, 1 = address out of range
//   load_we    program load write strobe (honoured only when idle)
//   load_addr  program load word address
//   load_data  program load word
//   busy       high while a fetch is in WAIT or RESP
module inst_mem_responder #(
  parameter int          ADDR_W      = 16,
  parameter int          DEPTH       = 256,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] NOP_INST    = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [15:0]       if_inst,
  output logic              if_err,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [15:0]       load_data,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // DEPTH widened by one bit so DEPTH == 2**ADDR_W still compares correctly
  localparam logic [ADDR_W:0] DEPTH_X   = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state;
  logic [3:0]        wait_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       mem [DEPTH];

  logic        load_ok;
  logic        req_take;
  logic        addr_in;
  logic [15:0] rd_word;
  logic [15:0] rsp_word;
  logic        pf_hit;

  assign load_ok  = (state == S_IDLE) && load_we && ({1'b0, load_addr} < DEPTH_X);
  // a load in IDLE wins; the request is picked up on a later cycle
  assign req_take = (state == S_IDLE) && !load_we && if_req;
  assign addr_in  = ({1'b0, addr_q} < DEPTH_X);
  assign rd_word  = mem[addr_q[IDX_W-1:0]];
  assign busy     = (state != S_IDLE);

  // array and latched fetch address carry no reset; contents survive rst
  always_ff @(posedge clk) begin
    if (load_ok)
      mem[load_addr[IDX_W-1:0]] <= load_data;
    if (req_take)
      addr_q <= if_addr;
  end

`ifdef INST_PREFETCH_EN
  logic              pf_vld;
  logic [ADDR_W-1:0] pf_tag;
  logic [15:0]       pf_data;
  logic              hit_q;
  logic [ADDR_W:0]   nx_addr;
  logic              nx_ok;

  assign pf_hit   = pf_vld && (if_addr == pf_tag);
  assign nx_addr  = {1'b0, addr_q} + (ADDR_W+1)'(1);
  assign nx_ok    = addr_in && (nx_addr < DEPTH_X);
  assign rsp_word = hit_q ? pf_data : rd_word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pf_vld <= 1'b0;
      hit_q  <= 1'b0;
    end else begin
      if (state == S_IDLE && load_we && pf_vld && load_addr == pf_tag)
        pf_vld <= 1'b0;
      if (req_take)
        hit_q <= pf_hit;
      // refill with the sequentially next word on every response
      if (state == S_RESP)
        pf_vld <= nx_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_RESP && nx_ok) begin
      pf_tag  <= nx_addr[ADDR_W-1:0];
      pf_data <= mem[nx_addr[IDX_W-1:0]];
    end
  end
`else
  assign pf_hit   = 1'b0;
  assign rsp_word = rd_word;
`endif

  // control FSM; if_ack rises on the edge that leaves RESP
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      if_ack   <= 1'b0;
      if_inst  <= 16'h0000;
      if_err   <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_take) begin
            if (pf_hit || WAIT_CYCLES == 0) begin
              state <= S_RESP;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= WAIT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0)
            state <= S_RESP;
          else
            wait_cnt <= wait_cnt - 4'd1;
        end
        S_RESP: begin
          if_ack  <= 1'b1;
          if_inst <= addr_in ? rsp_word : NOP_INST;
          if_err  <= !addr_in;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_responder.sv
module tb_inst_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = 16'h0000;
  logic        if_ack;
  logic [15:0] if_inst;
  logic        if_err;
  logic        load_we = 1'b0;
  logic [15:0] load_addr = 16'h0000;
  logic [15:0] load_data = 16'h0000;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  localparam int LAT_FULL = 4;  // edges N..N+3 with WAIT_CYCLES=2
`ifdef INST_PREFETCH_EN
  localparam int LAT_HIT = 2;
`else
  localparam int LAT_HIT = 4;
`endif

  inst_mem_responder dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ack   (if_ack),
    .if_inst  (if_inst),
    .if_err   (if_err),
    .load_we  (load_we),
    .load_addr(load_addr),
    .load_data(load_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic load_word(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    load_we = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    check("load_no_ack", {31'd0, if_ack}, 32'd0);
    @(negedge clk);
    load_we = 1'b0;
  endtask

  // lat = number of rising edges from the sampling edge up to the one after
  // which if_ack is seen high
  task automatic wait_ack(input string tag, output int lat, output logic [15:0] inst,
                          output logic err, output logic bsy);
    bit got;
    got = 1'b0; lat = 0; bsy = 1'b0; inst = 16'hxxxx; err = 1'bx;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) bsy = busy;
      if (if_ack) begin
        got  = 1'b1;
        inst = if_inst;
        err  = if_err;
      end
    end
    if_req = 1'b0;
    check({tag, "_ack_seen"}, {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    check({tag, "_ack_one_cycle"}, {31'd0, if_ack}, 32'd0);
  endtask

  task automatic fetch(input string tag, input logic [15:0] a, input int exp_lat,
                       input logic [15:0] exp_inst, input logic exp_err);
    int lat; logic [15:0] inst; logic err; logic bsy;
    @(negedge clk);
    if_req = 1'b1; if_addr = a;
    wait_ack(tag, lat, inst, err, bsy);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_inst"}, {16'd0, inst}, {16'd0, exp_inst});
    check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    check({tag, "_busy"}, {31'd0, bsy}, 32'd1);
  endtask

  initial begin
    int lat; logic [15:0] inst; logic err; logic bsy; bit saw_ack;

    // 1: reset values, then program load
    for (int i = 0; i < 3; i++) begin
      #9;
      check("rst_ack", {31'd0, if_ack}, 32'd0);
      check("rst_inst", {16'd0, if_inst}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
    end
    #3 rst = 1'b1;  // released at 30 ns
    load_word(16'd0, 16'h1111);
    load_word(16'd1, 16'h2222);
    load_word(16'd2, 16'h3333);
    load_word(16'd3, 16'h4444);

    // 2: basic fetch, inst holds afterwards
    fetch("f0", 16'd0, LAT_FULL, 16'h1111, 1'b0);
    repeat (3) @(posedge clk); #1;
    check("f0_hold", {16'd0, if_inst}, 32'h1111);

    // 3: DEPTH boundary and top of range
    fetch("oor", 16'h0100, LAT_FULL, 16'h0000, 1'b1);
    fetch("oor_max", 16'hFFFF, LAT_FULL, 16'h0000, 1'b1);
    load_word(16'h0100, 16'h7777);   // ignored, out of range
    load_word(16'h00FF, 16'hBEEF);
    fetch("last", 16'h00FF, LAT_FULL, 16'hBEEF, 1'b0);
    fetch("oor2", 16'h0100, LAT_FULL, 16'h0000, 1'b1);

    // 4: simultaneous load and request; load first, one extra cycle
    @(negedge clk);
    load_we = 1'b1; load_addr = 16'd2; load_data = 16'hABCD;
    if_req = 1'b1;  if_addr = 16'd2;
    @(posedge clk); #1;
    check("ld_req_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    load_we = 1'b0;
    wait_ack("ldreq", lat, inst, err, bsy);
    check("ldreq_lat", lat, LAT_FULL);
    check("ldreq_inst", {16'd0, inst}, 32'hABCD);
    check("ldreq_err", {31'd0, err}, 32'd0);

    // 5: reset during WAIT aborts without ack
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'd3;
    @(posedge clk); #1;
    check("abort_busy_wait", {31'd0, busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_inst", {16'd0, if_inst}, 32'd0);
    if_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    saw_ack = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (if_ack || busy) saw_ack = 1'b1;
    end
    check("abort_no_ack", {31'd0, saw_ack}, 32'd0);
    fetch("after_rst", 16'd1, LAT_FULL, 16'h2222, 1'b0);

    // 6: sequential fetches, prefetch hits when enabled; load invalidates
    fetch("seq0", 16'd0, LAT_FULL, 16'h1111, 1'b0);
    fetch("seq1", 16'd1, LAT_HIT, 16'h2222, 1'b0);
    fetch("seq2", 16'd2, LAT_HIT, 16'hABCD, 1'b0);
    load_word(16'd3, 16'h5A5A);
    fetch("seq3", 16'd3, LAT_FULL, 16'h5A5A, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
